timer_ctrl: RTL and testbench



---
 rtl/timer_pkg.sv | 20 ++
 rtl/timer_ctrl_if.sv | 26 ++
 rtl/timer_ctrl_bcd_down_digit.sv | 37 +++
 rtl/timer_ctrl.sv | 168 ++++++++++++++++
 tb/tb_timer_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared encodings and limits for the countdown timer controller and its digit counters.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] SEC_MAX  = 4'd9;
  localparam logic [3:0] DSEC_MAX = 4'd5;

  localparam int AUTOCLR_TICKS = 3;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Keypad/command/tick inputs and BCD display outputs of the countdown timer.
interface timer_ctrl_if;

  logic       tick;
  logic       key_valid;
  logic [3:0] key;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] min;
  logic [3:0] dsec;
  logic [3:0] sec;
  logic       running;
  logic       done;

  modport master (
    output tick, key_valid, key, start, stop, clear,
    input  min, dsec, sec, running, done
  );

  modport slave (
    input  tick, key_valid, key, start, stop, clear,
    output min, dsec, sec, running, done
  );

endinterface

// File: rtl/timer_ctrl_bcd_down_digit.sv
// One BCD down-counting digit: load has priority over decrement, wraps 0 -> max_val.
// borrow is high while the digit holds 0, so chained digits step on the wrap.
module bcd_down_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic [3:0] max_val,
  output logic [3:0] value,
  output logic       borrow
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en) begin
      value_d = (value_q == 4'd0) ? max_val : (value_q - 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign borrow = (value_q == 4'd0);

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer: keypad entry, start/stop/clear, 1 Hz decrement, completion flag at 0:00.
// Optional TIMER_AUTOCLEAR_EN: DONE returns to IDLE after a fixed number of ticks.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned MAX_MIN = 9
) (
  input  logic         clk,
  input  logic         reset,
  timer_ctrl_if.slave  bus
);

  localparam logic [3:0] MIN_LIMIT = 4'(MAX_MIN);

  state_e state_q;
  state_e state_d;

  logic       dec_en;
  logic       load;
  logic [3:0] ld_min;
  logic [3:0] ld_dsec;
  logic [3:0] ld_sec;

  logic [3:0] min_v;
  logic [3:0] dsec_v;
  logic [3:0] sec_v;
  logic       min_b;
  logic       dsec_b;
  logic       sec_b;

  logic       nonzero;
  logic       key_ok;
  logic       last_sec;

`ifdef TIMER_AUTOCLEAR_EN
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
`endif

  // Borrow chain: each higher digit steps only when every lower digit wraps.
  bcd_down_digit u_sec (
    .clk      (clk),
    .rst      (reset),
    .en       (dec_en),
    .load     (load),
    .load_val (ld_sec),
    .max_val  (SEC_MAX),
    .value    (sec_v),
    .borrow   (sec_b)
  );

  bcd_down_digit u_dsec (
    .clk      (clk),
    .rst      (reset),
    .en       (dec_en & sec_b),
    .load     (load),
    .load_val (ld_dsec),
    .max_val  (DSEC_MAX),
    .value    (dsec_v),
    .borrow   (dsec_b)
  );

  bcd_down_digit u_min (
    .clk      (clk),
    .rst      (reset),
    .en       (dec_en & sec_b & dsec_b),
    .load     (load),
    .load_val (ld_min),
    .max_val  (MIN_LIMIT),
    .value    (min_v),
    .borrow   (min_b)
  );

  assign nonzero  = !(min_b & dsec_b & sec_b);
  assign last_sec = min_b & dsec_b & (sec_v == 4'd1);
  // The shifted-in digits must stay in range: old sec becomes dsec, old dsec becomes min.
  assign key_ok   = bus.key_valid && is_digit(bus.key) &&
                    (sec_v <= DSEC_MAX) && (dsec_v <= MIN_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dec_en  = 1'b0;
    load    = 1'b0;
    ld_min  = 4'd0;
    ld_dsec = 4'd0;
    ld_sec  = 4'd0;
    if (bus.clear) begin
      state_d = ST_IDLE;
      load    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && nonzero) begin
            state_d = ST_RUN;
          end else if (key_ok) begin
            load    = 1'b1;
            ld_min  = dsec_v;
            ld_dsec = sec_v;
            ld_sec  = bus.key;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_PAUSE;
          end else if (bus.tick) begin
            dec_en = 1'b1;
            if (last_sec) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
`ifdef TIMER_AUTOCLEAR_EN
          if (bus.tick && (cnt_q == 2'(AUTOCLR_TICKS - 1))) begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_DONE;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef TIMER_AUTOCLEAR_EN
  // Held at zero outside DONE, so every DONE entry starts a fresh count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ST_DONE) begin
      cnt_d = 2'd0;
    end else if (bus.tick) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    bus.running = (state_q == ST_RUN);
    bus.done    = (state_q == ST_DONE);
  end

  assign bus.min  = min_v;
  assign bus.dsec = dsec_v;
  assign bus.sec  = sec_v;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus random commands against a total-seconds model.
module tb_timer_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;
  localparam int MAXMIN  = 9;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  timer_ctrl_if bus ();

  timer_ctrl #(.MAX_MIN(MAXMIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: remaining time in whole seconds, plus a coarse mode.
  int m_t   = 0;
  int m_st  = M_IDLE;
  int m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".min"},     32'(bus.min),     32'(m_t / 60));
    chk({tag, ".dsec"},    32'(bus.dsec),    32'((m_t % 60) / 10));
    chk({tag, ".sec"},     32'(bus.sec),     32'(m_t % 10));
    chk({tag, ".running"}, 32'(bus.running), 32'(m_st == M_RUN));
    chk({tag, ".done"},    32'(bus.done),    32'(m_st == M_DONE));
  endtask

  task automatic model_apply(input bit tk, input bit kv, input int k,
                             input bit st, input bit sp, input bit cl);
    int m, d, s;
    if (cl) begin
      m_st = M_IDLE; m_t = 0; m_cnt = 0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (st && m_t > 0) begin
            m_st = M_RUN;
          end else if (kv && k <= 9) begin
            m = m_t / 60; d = (m_t % 60) / 10; s = m_t % 10;
            if (s <= 5 && d <= MAXMIN) m_t = d * 60 + s * 10 + k;
          end
        end
        M_RUN: begin
          if (sp) begin
            m_st = M_PAUSE;
          end else if (tk) begin
            m_t = m_t - 1;
            if (m_t == 0) begin m_st = M_DONE; m_cnt = 0; end
          end
        end
        M_PAUSE: if (st) m_st = M_RUN;
        default: begin
`ifdef TIMER_AUTOCLEAR_EN
          if (tk) begin
            m_cnt++;
            if (m_cnt == 3) m_st = M_IDLE;
          end
`endif
        end
      endcase
    end
  endtask

  task automatic step(input string tag, input bit tk, input bit kv, input int k,
                      input bit st, input bit sp, input bit cl);
    bus.tick = tk; bus.key_valid = kv; bus.key = 4'(k);
    bus.start = st; bus.stop = sp; bus.clear = cl;
    @(posedge clk);
    model_apply(tk, kv, k, st, sp, cl);
    #1;
    bus.tick = 0; bus.key_valid = 0; bus.key = 4'd0;
    bus.start = 0; bus.stop = 0; bus.clear = 0;
    check_all(tag);
  endtask

  task automatic key(input int k);   step("key", 0, 1, k, 0, 0, 0); endtask
  task automatic tick();             step("tick", 1, 0, 0, 0, 0, 0); endtask
  task automatic go();               step("start", 0, 0, 0, 1, 0, 0); endtask
  task automatic clr();              step("clear", 0, 0, 0, 0, 0, 1); endtask

  initial begin
    bus.tick = 0; bus.key_valid = 0; bus.key = 4'd0;
    bus.start = 0; bus.stop = 0; bus.clear = 0;
    reset = 1'b1;
    #1;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset_release");

    // Entry 1,3,0 then a full countdown to completion.
    key(1); key(3); key(0);
    chk("entry130", {20'd0, bus.min, bus.dsec, bus.sec}, 32'h130);
    go();
    chk("run130.running", 32'(bus.running), 32'd1);
    for (int i = 0; i < 91; i++) begin
      if (i % 7 == 3) step("gap", 0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("countdown.done", 32'(bus.done), 32'd1);
    chk("countdown.digits", {20'd0, bus.min, bus.dsec, bus.sec}, 32'h000);

    // Out-of-range and non-digit keys are dropped.
    clr(); key(1); key(7);
    key(5);
    chk("drop_dsec7", {20'd0, bus.min, bus.dsec, bus.sec}, 32'h017);
    key(12);
    chk("drop_key12", {20'd0, bus.min, bus.dsec, bus.sec}, 32'h017);

    // tick+stop pauses without decrement; pause ignores ticks and keys.
    clr(); key(1); key(0); go();
    step("tick_stop", 1, 0, 0, 0, 1, 0);
    chk("paused.digits", {20'd0, bus.min, bus.dsec, bus.sec}, 32'h010);
    for (int i = 0; i < 5; i++) tick();
    key(4);
    chk("paused_hold", {20'd0, bus.min, bus.dsec, bus.sec}, 32'h010);
    step("tick_start", 1, 0, 0, 1, 0, 0);
    chk("resume.digits", {20'd0, bus.min, bus.dsec, bus.sec}, 32'h010);
    tick();
    chk("resume_tick", {20'd0, bus.min, bus.dsec, bus.sec}, 32'h009);

    // Borrow through both lower digits.
    clr(); key(2); key(0); key(0); go(); tick();
    chk("borrow_chain", {20'd0, bus.min, bus.dsec, bus.sec}, 32'h159);
    clr(); go();
    chk("start_zero.running", 32'(bus.running), 32'd0);

    // tick+clear while running.
    key(3); go();
    step("tick_clear", 1, 0, 0, 0, 0, 1);

    // DONE followed by three ticks.
    clr(); key(1); go(); tick();
    chk("done_entry", 32'(bus.done), 32'd1);
    tick(); tick(); tick();
`ifdef TIMER_AUTOCLEAR_EN
    chk("autoclear.done", 32'(bus.done), 32'd0);
`else
    chk("persist.done", 32'(bus.done), 32'd1);
`endif
    clr();

    // Asynchronous reset in the middle of a count.
    key(1); key(2); key(3); go();
    #2 reset = 1'b1;
    #1;
    m_st = M_IDLE; m_t = 0; m_cnt = 0;
    check_all("reset_mid_run");
    @(negedge clk);
    reset = 1'b0;

    // Random single-event traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 35)      tick();
      else if (r < 62) key(int'($urandom_range(0, 15)));
      else if (r < 74) go();
      else if (r < 81) step("stop", 0, 0, 0, 0, 1, 0);
      else if (r < 84) clr();
      else             step("idle", 0, 0, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
